// File: rtl/rr_enc_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin
// request encoder front end.
package rr_enc_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    function automatic logic [N-1:0] onehot8(input logic [IDXW-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: rotate candidates so ptr is bit 0, take the lowest set
// bit, then rotate the offset back into an absolute line index.
module rr_pick8
    import rr_enc_pkg::*;
(
    input  logic [N-1:0]    cand,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] pick,
    output logic            any
);

    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;

    always_comb begin
        rot = '0;
        off = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            rot[i] = cand[IDXW'(i) + ptr];
        end
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = IDXW'(i);
            end
        end
        pick = off + ptr;
    end

endmodule

// File: rtl/rr_req_encoder8.sv
// Sticky request capture with round-robin grant, presented as index plus
// one-hot word over a valid/ready handshake.
module rr_req_encoder8
    import rr_enc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    out_onehot,
    output logic [N-1:0]    pending_o,
    output logic            drop_o
);

    rr_state_e       state, state_next;
    logic [N-1:0]    pending, pending_next;
    logic [IDXW-1:0] ptr, ptr_next, idx_next, pick_ptr, pick;
    logic [N-1:0]    clr, hold, cand;
    logic            hs, any;

    assign hs           = (state == GRANT) && out_ready;
    assign clr          = hs ? onehot8(out_idx) : '0;
    // A same-edge request on the line being cleared is a fresh event and survives.
    assign pending_next = (pending & ~clr) | req_i;
    // A stalled grant must not be offered again as a candidate.
    assign hold         = ((state == GRANT) && !hs) ? onehot8(out_idx) : '0;
    assign cand         = pending_next & ~hold;
    assign pick_ptr     = hs ? (out_idx + IDXW'(1)) : ptr;

    rr_pick8 u_pick (
        .cand (cand),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_next = state;
        idx_next   = out_idx;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (any) begin
                    state_next = GRANT;
                    idx_next   = pick;
                end
            end
            GRANT: begin
                if (hs) begin
                    ptr_next = out_idx + IDXW'(1);
                    if (any) idx_next   = pick;
                    else     state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= '0;
            out_idx <= '0;
            drop_o  <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            ptr     <= ptr_next;
            out_idx <= idx_next;
            drop_o  <= |(req_i & pending & ~clr);
        end
    end

    assign out_valid  = (state == GRANT);
    assign out_onehot = out_valid ? onehot8(out_idx) : '0;
    assign pending_o  = pending;

endmodule

// File: tb/tb_rr_req_encoder8.sv
// Directed bench for rr_req_encoder8: reset, latency, round-robin order,
// stall hold, drop detection and asynchronous reset mid-grant.
module tb_rr_req_encoder8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic [7:0] pending_o;
    logic       drop_o;

    int n_checks;
    int n_fail;

    rr_req_encoder8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending_o  (pending_o),
        .drop_o     (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_i     = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_i     = 8'h00;
        out_ready = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_idx, out_onehot, pending_o, drop_o} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b idx=%0d onehot=%h pend=%h drop=%0b, want all 0",
                     out_valid, out_idx, out_onehot, pending_o, drop_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req_i     = 8'b0010_0000;
        tick();
        req_i = 8'h00;
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd5 || out_onehot !== 8'h20 || pending_o !== 8'h20) begin
            n_fail++;
            $display("FAIL single_grant: valid=%0b idx=%0d onehot=%h pend=%h, want 1 5 20 20",
                     out_valid, out_idx, out_onehot, pending_o);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00 || out_onehot !== 8'h00) begin
            n_fail++;
            $display("FAIL single_done: valid=%0b pend=%h onehot=%h, want 0 00 00",
                     out_valid, pending_o, out_onehot);
        end
    endtask

    task automatic test_all_lines();
        do_reset();
        out_ready = 1'b1;
        req_i     = 8'hFF;
        tick();
        req_i = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_onehot !== (8'h01 << i)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: valid=%0b idx=%0d onehot=%h, want 1 %0d",
                         i, out_valid, out_idx, out_onehot, i);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL rr_drain: valid=%0b pend=%h, want 0 00", out_valid, pending_o);
        end
    endtask

    task automatic test_wrap();
        req_i = 8'h81;
        tick();
        req_i = 8'h00;
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_first: valid=%0b idx=%0d, want 1 0", out_valid, out_idx);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_onehot !== 8'h80) begin
            n_fail++;
            $display("FAIL wrap_second: valid=%0b idx=%0d onehot=%h, want 1 7 80",
                     out_valid, out_idx, out_onehot);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        req_i     = 8'h0C;
        tick();
        req_i = 8'h00;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd2 || pending_o !== 8'h0C) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%0b idx=%0d pend=%h, want 1 2 0c",
                         i, out_valid, out_idx, pending_o);
            end
            tick();
        end
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL stall_release: valid=%0b idx=%0d, want 1 2", out_valid, out_idx);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending_o !== 8'h08) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%0b idx=%0d pend=%h, want 1 3 08",
                     out_valid, out_idx, pending_o);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_drop();
        do_reset();
        out_ready = 1'b0;
        req_i     = 8'h11;
        tick();
        req_i = 8'h10;
        n_checks++;
        if (out_idx !== 3'd0 || drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_setup: idx=%0d drop=%0b, want 0 0", out_idx, drop_o);
        end
        tick();
        req_i = 8'h00;
        n_checks++;
        if (drop_o !== 1'b1 || pending_o !== 8'h11) begin
            n_fail++;
            $display("FAIL drop_pulse: drop=%0b pend=%h, want 1 11", drop_o, pending_o);
        end
        tick();
        n_checks++;
        if (drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: drop=%0b, want 0", drop_o);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL drop_grant4: valid=%0b idx=%0d, want 1 4", out_valid, out_idx);
        end
        req_i = 8'h10;
        tick();
        req_i = 8'h00;
        n_checks++;
        if (drop_o !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd4 || pending_o !== 8'h10) begin
            n_fail++;
            $display("FAIL same_cycle_rereq: drop=%0b valid=%0b idx=%0d pend=%h, want 0 1 4 10",
                     drop_o, out_valid, out_idx, pending_o);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_idle: valid=%0b pend=%h, want 0 00", out_valid, pending_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        req_i     = 8'hF0;
        tick();
        req_i = 8'h00;
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending_o !== 8'hF0) begin
            n_fail++;
            $display("FAIL arst_setup: valid=%0b idx=%0d pend=%h, want 1 4 f0",
                     out_valid, out_idx, pending_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00 || out_idx !== 3'd0 || out_onehot !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_immediate: valid=%0b pend=%h idx=%0d onehot=%h, want 0 00 0 00",
                     out_valid, pending_o, out_idx, out_onehot);
        end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_no_grant: valid=%0b pend=%h, want 0 00", out_valid, pending_o);
        end
        req_i = 8'h40;
        tick();
        req_i = 8'h00;
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd6) begin
            n_fail++;
            $display("FAIL arst_new_req: valid=%0b idx=%0d, want 1 6", out_valid, out_idx);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_i     = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_all_lines();
        test_wrap();
        test_stall();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
